store_commit_ctrl: RTL and testbench

STORE_COMMIT_CTRL -- requirements
Module: store_commit_ctrl

---
 rtl/store_commit_ctrl_pkg.sv | 27 ++
 rtl/store_commit_ctrl.sv | 143 ++++++++++++++
 tb/tb_store_commit_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_commit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// store_commit_ctrl_pkg : shared types and defaults for the store commit path
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package store_commit_ctrl_pkg;

  localparam int SQ_SIZE_DEF      = 8;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ST_ISSUE = 2'd1,
    LD_ISSUE = 2'd2,
    LD_WAIT  = 2'd3
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/store_commit_ctrl.sv
// ---------------------------------------------------------------------------
// store_commit_ctrl : arbitrates one memory port between retired stores and loads
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_commit_ctrl
  import store_commit_ctrl_pkg::*;
#(
  parameter int SQ_SIZE      = SQ_SIZE_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rt_store,
  input  logic [31:0] sq_head_addr,
  input  logic [63:0] sq_head_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  mem_response,
  input  logic [3:0]  mem_tag,
  input  logic [63:0] mem_rdata,
  output mem_cmd_t    mem_cmd,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_data,
  output logic        sq_rt_en,
  output logic        ld_gnt,
  output logic        ld_done,
  output logic [63:0] ld_data,
  output logic        store_pending
);

  localparam int CNT_W = $clog2(SQ_SIZE) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SQ_SIZE);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  ctrl_state_t      state;
  logic [CNT_W-1:0] pend_cnt;
  logic [STV_W-1:0] starve_cnt;
  logic [31:0]      ld_addr_q;
  logic [3:0]       ld_tag_q;

  logic pend_nonzero;
  logic pend_full;
  logic store_wins;

  assign pend_nonzero  = (pend_cnt != '0);
  assign pend_full     = (pend_cnt == CNT_FULL);
  assign store_pending = pend_nonzero;

  // A waiting store takes the port when loads are idle, it has been starved long enough, or the queue is full.
  assign store_wins = pend_nonzero &&
                      (!ld_req || (starve_cnt == STV_MAX) || pend_full);

  always_comb begin
    mem_cmd  = NONE;
    mem_addr = '0;
    mem_data = '0;
    sq_rt_en = 1'b0;
    ld_gnt   = 1'b0;
    ld_done  = 1'b0;
    ld_data  = '0;
    case (state)
      ST_ISSUE: begin
        mem_cmd  = STORE;
        mem_addr = sq_head_addr;
        mem_data = sq_head_data;
        sq_rt_en = (mem_response != 4'd0);
      end
      LD_ISSUE: begin
        mem_cmd  = LOAD;
        mem_addr = ld_addr_q;
        ld_gnt   = (mem_response != 4'd0);
      end
      LD_WAIT: begin
        if ((ld_tag_q != 4'd0) && (mem_tag == ld_tag_q)) begin
          ld_done = 1'b1;
          ld_data = mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else begin
      case ({rt_store, sq_rt_en})
        2'b10: if (!pend_full) pend_cnt <= pend_cnt + CNT_W'(1);
        2'b01: if (pend_nonzero) pend_cnt <= pend_cnt - CNT_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (sq_rt_en || !pend_nonzero) begin
      starve_cnt <= '0;
    end else if (ld_gnt && (starve_cnt != STV_MAX)) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ld_addr_q <= '0;
      ld_tag_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_wins) begin
            state <= ST_ISSUE;
          end else if (ld_req) begin
            state     <= LD_ISSUE;
            ld_addr_q <= ld_addr;
          end
        end
        ST_ISSUE: if (sq_rt_en) state <= IDLE;
        LD_ISSUE: begin
          if (ld_gnt) begin
            ld_tag_q <= mem_response;
            state    <= LD_WAIT;
          end
        end
        LD_WAIT: if (ld_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Retiring into a full queue without a same-cycle commit means the ROB overran the store queue.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(rt_store && pend_full && !sq_rt_en));

endmodule

`default_nettype wire

// File: tb/tb_store_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_store_commit_ctrl : directed bench with a cycle-level behavioural reference
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_store_commit_ctrl;
  import store_commit_ctrl_pkg::*;

  localparam int SQ = 8;
  localparam int LIM = 4;

  logic        clk;
  logic        rst_n;
  logic        rt_store;
  logic [31:0] sq_head_addr;
  logic [63:0] sq_head_data;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [3:0]  mem_response;
  logic [3:0]  mem_tag;
  logic [63:0] mem_rdata;
  mem_cmd_t    mem_cmd;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic        sq_rt_en;
  logic        ld_gnt;
  logic        ld_done;
  logic [63:0] ld_data;
  logic        store_pending;

  int n_checks = 0;
  int n_fail   = 0;

  store_commit_ctrl #(.SQ_SIZE(SQ), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .rt_store(rt_store),
    .sq_head_addr(sq_head_addr), .sq_head_data(sq_head_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .mem_response(mem_response),
    .mem_tag(mem_tag), .mem_rdata(mem_rdata), .mem_cmd(mem_cmd),
    .mem_addr(mem_addr), .mem_data(mem_data), .sq_rt_en(sq_rt_en),
    .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_data(ld_data),
    .store_pending(store_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what the port must be doing, tracked as "retired stores owed",
  // "loads granted while a store waited", and which memory operation is in flight.
  int          m_owed;
  int          m_starved;
  bit          m_store_busy, m_load_asking, m_load_waiting;
  logic [31:0] m_ld_addr;
  logic [3:0]  m_ld_tag;

  always @(negedge clk) begin
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_data, e_ldata;
    bit          e_commit, e_grant, e_done;
    if (!rst_n) begin
      m_owed = 0; m_starved = 0;
      m_store_busy = 0; m_load_asking = 0; m_load_waiting = 0;
      m_ld_addr = '0; m_ld_tag = '0;
      chk("rst_mem_cmd", 64'(mem_cmd), 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_outs", {sq_rt_en, ld_gnt, ld_done, store_pending}, 0);
      chk("rst_ld_data", ld_data, 0);
    end else begin
      e_cmd = 2'd0; e_addr = '0; e_data = '0; e_ldata = '0;
      e_commit = m_store_busy && (mem_response != 0);
      e_grant  = m_load_asking && (mem_response != 0);
      e_done   = m_load_waiting && (m_ld_tag != 0) && (mem_tag == m_ld_tag);
      if (m_store_busy) begin
        e_cmd = 2'd2; e_addr = sq_head_addr; e_data = sq_head_data;
      end
      if (m_load_asking) begin
        e_cmd = 2'd1; e_addr = m_ld_addr;
      end
      if (e_done) e_ldata = mem_rdata;
      chk("mem_cmd", 64'(mem_cmd), 64'(e_cmd));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_data", mem_data, e_data);
      chk("sq_rt_en", 64'(sq_rt_en), 64'(e_commit));
      chk("ld_gnt", 64'(ld_gnt), 64'(e_grant));
      chk("ld_done", 64'(ld_done), 64'(e_done));
      chk("ld_data", ld_data, e_ldata);
      chk("store_pending", 64'(store_pending), 64'(m_owed != 0));
      // advance to what the next edge produces
      if (e_commit || m_owed == 0) m_starved = 0;
      else if (e_grant) m_starved = (m_starved + 1 > LIM) ? LIM : m_starved + 1;
      if (m_store_busy) begin
        if (e_commit) m_store_busy = 0;
      end else if (m_load_asking) begin
        if (e_grant) begin m_load_asking = 0; m_load_waiting = 1; m_ld_tag = mem_response; end
      end else if (m_load_waiting) begin
        if (e_done) m_load_waiting = 0;
      end else if (m_owed > 0 && (!ld_req || m_starved >= LIM || m_owed >= SQ)) begin
        m_store_busy = 1;
      end else if (ld_req) begin
        m_load_asking = 1; m_ld_addr = ld_addr;
      end
      m_owed = m_owed + int'(rt_store) - int'(e_commit);
      if (m_owed > SQ) m_owed = SQ;
      if (m_owed < 0) m_owed = 0;
    end
  end

  task automatic drain(input string name, input int exp_n);
    int got;
    bit ok;
    got = 0; ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      mem_response = (mem_cmd == STORE) ? 4'd1 : 4'd0;
      #1;
      if (sq_rt_en) got++;
      tick();
      mem_response = 4'd0;
      if (!store_pending) ok = 1;
    end
    chk({name, "_done"}, 64'(ok), 1);
    chk({name, "_commits"}, 64'(got), 64'(exp_n));
  endtask

  initial begin
    int gnts;
    bit got_store, tag_next;
    rst_n = 1'b0; rt_store = 0; ld_req = 0; ld_addr = '0;
    sq_head_addr = 32'h0000_1000; sq_head_data = 64'h1111_2222_3333_4444;
    mem_response = '0; mem_tag = '0; mem_rdata = '0;
    tick();
    chk("reset_cmd", 64'(mem_cmd), 0);
    chk("reset_pending", 64'(store_pending), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single store commit: accepted on the third STORE cycle
    rt_store = 1; tick(); rt_store = 0;
    #1 chk("st_pend_1", 64'(dut.pend_cnt), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_response = (i == 2) ? 4'd3 : 4'd0;
      #1;
      chk("st_cmd", 64'(mem_cmd), 64'(STORE));
      chk("st_rt_en", 64'(sq_rt_en), 64'(i == 2));
      tick();
    end
    mem_response = 0;
    #1 chk("st_pend_0", 64'(dut.pend_cnt), 0);
    chk("st_pending_drop", 64'(store_pending), 0);

    // plain load
    ld_req = 1; ld_addr = 32'h100; tick();
    ld_req = 0; mem_response = 4'd5;
    #1 chk("ld_gnt", 64'(ld_gnt), 1);
    chk("ld_addr", 64'(mem_addr), 64'h100);
    tick(); mem_response = 0;
    #1 chk("ld_wait_cmd", 64'(mem_cmd), 64'(NONE));
    tick();
    mem_tag = 4'd5; mem_rdata = 64'hDEAD;
    #1 chk("ld_done", 64'(ld_done), 1);
    chk("ld_data", ld_data, 64'hDEAD);
    tick(); mem_tag = 0; mem_rdata = 0;

    // starvation: exactly LIM grants before the waiting store wins
    ld_req = 1; ld_addr = 32'h200; rt_store = 1; tick(); rt_store = 0;
    gnts = 0; got_store = 0; tag_next = 0;
    for (int c = 0; c < 80 && !got_store; c++) begin
      mem_response = 0; mem_tag = 0;
      if (tag_next) begin mem_tag = 4'd7; tag_next = 0; end
      if (mem_cmd == LOAD) mem_response = 4'd7;
      else if (mem_cmd == STORE) mem_response = 4'd2;
      #1;
      if (ld_gnt) begin gnts++; tag_next = 1; end
      if (sq_rt_en) got_store = 1;
      tick();
    end
    chk("starve_store_seen", 64'(got_store), 1);
    chk("starve_gnts", 64'(gnts), 4);
    ld_req = 0; mem_response = 0; mem_tag = 0;
    #1 chk("starve_cleared", 64'(dut.starve_cnt), 0);
    tick();

    // retire and commit in the same cycle with two owed
    rt_store = 1; tick(); tick();
    mem_response = 4'd1;
    #1 chk("simul_rt_en", 64'(sq_rt_en), 1);
    tick(); rt_store = 0; mem_response = 0;
    #1 chk("simul_pend_2", 64'(dut.pend_cnt), 2);
    drain("simul_drain", 2);

    // full queue beats a requesting load
    ld_req = 1; ld_addr = 32'h300; tick();
    mem_response = 4'd9; tick(); mem_response = 0;
    rt_store = 1; repeat (SQ) tick(); rt_store = 0;
    #1 chk("full_pend", 64'(dut.pend_cnt), 64'(SQ));
    mem_tag = 4'd9; tick(); mem_tag = 0;
    tick();
    #1 chk("full_store_first", 64'(mem_cmd), 64'(STORE));
    ld_req = 0;
    drain("full_drain", SQ);

    // reset during LD_WAIT abandons the load
    ld_req = 1; ld_addr = 32'h400; tick();
    ld_req = 0; mem_response = 4'hA; tick(); mem_response = 0;
    rst_n = 0;
    #1 chk("rst_mid_cmd", 64'(mem_cmd), 64'(NONE));
    tick(); tick();
    rst_n = 1; mem_tag = 4'hA; mem_rdata = 64'hBEEF;
    #1 chk("rst_no_done", 64'(ld_done), 0);
    tick();
    #1 chk("rst_idle_cmd", 64'(mem_cmd), 64'(NONE));
    chk("rst_no_done2", 64'(ld_done), 0);
    mem_tag = 0; mem_rdata = 0;
    tick();

    // a store retired on the reset-release edge is still counted
    rst_n = 0; tick();
    rst_n = 1; rt_store = 1; tick(); rt_store = 0;
    #1 chk("rel_pending", 64'(store_pending), 1);
    drain("rel_drain", 1);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
